ddr_sa_2ph_cal_ctrl: RTL and testbench

Digital offset-calibration controller for the 2-phase sense-amp receiver slice. It drives the sense-amp enable, calibration enable, and per-phase calibration code and direction. It observes the 0 and 180 phase data outputs and sweeps each phase's code until the output flips. Both phases are searched in parallel. Results are held for the slice's config path; the block sits in the DQ/CA receive slice, beside the sense-amp wrapper.

---
 rtl/ddr_sa_cal_pkg.sv | 19 +
 rtl/ddr_sa_cal_phase_search.sv | 87 ++++++++
 rtl/ddr_sa_2ph_cal_ctrl.sv | 137 +++++++++++++
 tb/tb_ddr_sa_2ph_cal_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_sa_cal_pkg.sv
// Shared types and sizing helpers for the 2-phase sense-amp offset calibration controller.
package ddr_sa_cal_pkg;

    localparam int CWIDTH_DEF = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_EVAL   = 3'd3,
        ST_DONE   = 3'd4
    } cal_state_e;

    // Ones-counter must hold the value NSAMP itself, hence one extra bit.
    function automatic int ones_width(input int nsamp);
        return $clog2(nsamp) + 1;
    endfunction

endpackage

// File: rtl/ddr_sa_cal_phase_search.sv
// One phase of the offset search: data synchronizer, majority vote over a step, and
// the code/polarity/lock/err state that walks the code upward until the output flips.
module ddr_sa_cal_phase_search
    import ddr_sa_cal_pkg::*;
#(
    parameter int CWIDTH = CWIDTH_DEF,
    parameter int NSAMP  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_data,
    input  logic              i_clr,
    input  logic              i_samp_clr,
    input  logic              i_sample_en,
    input  logic              i_eval,
    output logic [CWIDTH-1:0] o_code,
    output logic              o_dir,
    output logic              o_lock_nxt,
    output logic              o_err
);

    localparam int                OW   = ones_width(NSAMP);
    localparam logic [OW-1:0]     HALF = OW'(NSAMP / 2);
    localparam logic [CWIDTH-1:0] MAXC = '1;

    logic              r_sync1;
    logic              r_sync2;
    logic [OW-1:0]     r_ones;
    logic              r_pol;
    logic [CWIDTH-1:0] r_code;
    logic              r_dir;
    logic              r_lock;
    logic              r_err;
    logic              w_dec;

    assign w_dec = (r_ones > HALF);
    // Lock status as it will be after this cycle, so the FSM can leave EVAL directly.
    assign o_lock_nxt = r_lock | (i_eval & (r_code != '0) & ((w_dec != r_pol) | (r_code == MAXC)));

    // Two-flop synchronizer for the asynchronous sense-amp output.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_data;
            r_sync2 <= r_sync1;
        end
    end

    // Ones accumulation and per-step code decision.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_ones <= '0;
            r_pol  <= 1'b0;
            r_code <= '0;
            r_dir  <= 1'b0;
            r_lock <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            if (i_samp_clr) begin
                r_ones <= '0;
            end else if (i_sample_en && !r_lock) begin
                r_ones <= r_ones + OW'(r_sync2);
            end
            if (i_eval && !r_lock) begin
                if (r_code == '0) begin
                    r_pol  <= w_dec;
                    r_dir  <= w_dec;
                    r_code <= CWIDTH'(1);
                end else if (w_dec != r_pol) begin
                    r_lock <= 1'b1;
                end else if (r_code == MAXC) begin
                    r_lock <= 1'b1;
                    r_err  <= 1'b1;
                end else begin
                    r_code <= r_code + CWIDTH'(1);
                end
            end
        end
    end

    assign o_code = r_code;
    assign o_dir  = r_dir;
    assign o_err  = r_err;

endmodule

// File: rtl/ddr_sa_2ph_cal_ctrl.sv
// Offset-calibration controller for a 2-phase sense-amp slice; both phases are
// searched in lockstep by a shared settle/sample/eval sequencer.
module ddr_sa_2ph_cal_ctrl
    import ddr_sa_cal_pkg::*;
#(
    parameter int CWIDTH = CWIDTH_DEF,
    parameter int NSAMP  = 16,
    parameter int SWIDTH = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [SWIDTH-1:0] i_settle_cyc,
    input  logic              i_data_0,
    input  logic              i_data_180,
    output logic              o_sa_en,
    output logic              o_sacal_ena,
    output logic [CWIDTH-1:0] o_cal_code_0,
    output logic              o_cal_dir_0,
    output logic [CWIDTH-1:0] o_cal_code_180,
    output logic              o_cal_dir_180,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err_0,
    output logic              o_err_180
);

    localparam int              CNTW      = (SWIDTH > $clog2(NSAMP)) ? SWIDTH : $clog2(NSAMP);
    localparam logic [CNTW-1:0] SAMP_LAST = CNTW'(NSAMP - 1);

    cal_state_e        r_state;
    cal_state_e        w_next;
    logic [CNTW-1:0]   r_cnt;
    logic [SWIDTH-1:0] r_settle;
    logic              r_busy;
    logic              r_done;
    logic              w_start_acc;
    logic              w_lock_nxt_0;
    logic              w_lock_nxt_180;
    logic [SWIDTH-1:0] w_settle_in;
    logic [CNTW-1:0]   w_settle_last;
    logic              w_samp_clr;
    logic              w_sample_en;
    logic              w_eval;

    assign w_settle_in   = (i_settle_cyc == '0) ? SWIDTH'(1) : i_settle_cyc;
    assign w_settle_last = CNTW'(r_settle) - CNTW'(1);
    assign w_samp_clr    = (r_state == ST_SETTLE) && (w_next == ST_SAMPLE);
    assign w_sample_en   = (r_state == ST_SAMPLE);
    assign w_eval        = (r_state == ST_EVAL);

    // Next-state decode for the step sequencer.
    always_comb begin
        w_next      = r_state;
        w_start_acc = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    w_next      = ST_SETTLE;
                    w_start_acc = 1'b1;
                end else begin
                    w_next = r_state;
                end
            end
            ST_SETTLE: begin
                if (r_cnt == w_settle_last) w_next = ST_SAMPLE;
                else                        w_next = ST_SETTLE;
            end
            ST_SAMPLE: begin
                if (r_cnt == SAMP_LAST) w_next = ST_EVAL;
                else                    w_next = ST_SAMPLE;
            end
            ST_EVAL: begin
                if (w_lock_nxt_0 && w_lock_nxt_180) w_next = ST_DONE;
                else                                w_next = ST_SETTLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State, shared phase counter, latched settle length and status flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_settle <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next == ST_SETTLE && r_state != ST_SETTLE) begin
                r_settle <= w_settle_in;
            end
            if ((r_state == ST_SETTLE || r_state == ST_SAMPLE) && w_next == r_state) begin
                r_cnt <= r_cnt + CNTW'(1);
            end else begin
                r_cnt <= '0;
            end
            r_busy <= (w_next == ST_SETTLE) || (w_next == ST_SAMPLE) || (w_next == ST_EVAL);
            r_done <= (w_next == ST_DONE);
        end
    end

    ddr_sa_cal_phase_search #(.CWIDTH(CWIDTH), .NSAMP(NSAMP)) u_ph_0 (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_data      (i_data_0),
        .i_clr       (w_start_acc),
        .i_samp_clr  (w_samp_clr),
        .i_sample_en (w_sample_en),
        .i_eval      (w_eval),
        .o_code      (o_cal_code_0),
        .o_dir       (o_cal_dir_0),
        .o_lock_nxt  (w_lock_nxt_0),
        .o_err       (o_err_0)
    );

    ddr_sa_cal_phase_search #(.CWIDTH(CWIDTH), .NSAMP(NSAMP)) u_ph_180 (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_data      (i_data_180),
        .i_clr       (w_start_acc),
        .i_samp_clr  (w_samp_clr),
        .i_sample_en (w_sample_en),
        .i_eval      (w_eval),
        .o_code      (o_cal_code_180),
        .o_dir       (o_cal_dir_180),
        .o_lock_nxt  (w_lock_nxt_180),
        .o_err       (o_err_180)
    );

    assign o_sa_en     = r_busy;
    assign o_sacal_ena = r_busy;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_ddr_sa_2ph_cal_ctrl.sv
// Bench for ddr_sa_2ph_cal_ctrl: per-phase threshold/vote stimulus against a
// closed-form timeline model (outputs as a function of cycles since start).
module tb_ddr_sa_2ph_cal_ctrl;

    localparam int NS = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] settle;
    logic       d0, d180;
    logic       sa_en, sacal_ena, busy, done, dir0, dir180, err0, err180;
    logic [4:0] code0, code180;

    ddr_sa_2ph_cal_ctrl dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_settle_cyc   (settle),
        .i_data_0       (d0),
        .i_data_180     (d180),
        .o_sa_en        (sa_en),
        .o_sacal_ena    (sacal_ena),
        .o_cal_code_0   (code0),
        .o_cal_dir_0    (dir0),
        .o_cal_code_180 (code180),
        .o_cal_dir_180  (dir180),
        .o_busy         (busy),
        .o_done         (done),
        .o_err_0        (err0),
        .o_err_180      (err180)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Trial configuration / model state
    int          t0 = 0;
    bit          run_on = 1'b0;
    int          L = 21, S = 4;
    int          pp[2], th[2], vs[2], kl[2];
    bit          er[2];
    logic [15:0] vp[2];
    int          kmax = 0;
    int          done_off = -1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s t=%0d got=%0d exp=%0d", name, cyc - t0, act, exp);
        end
    endtask

    // Raw data for one phase at cycle offset n: vote pattern window, else threshold rule on current code.
    function automatic logic raw_bit(input int ph, input int n, input int code);
        logic [15:0] v;
        int          base;
        v    = vp[ph];
        base = L * vs[ph] + S - 1;
        if (vs[ph] > 0 && n >= base && n < base + NS) return v[n - base];
        return (code >= th[ph]) ? ~pp[ph][0] : pp[ph][0];
    endfunction

    // Stimulus driver for the sense-amp outputs.
    always @(negedge clk) begin
        d0   <= raw_bit(0, cyc - t0, int'(code0));
        d180 <= raw_bit(1, cyc - t0, int'(code180));
    end

    // Model compare: every cycle after the start cycle while a trial is active.
    int n_m, comp, ebusy, ec;
    always @(negedge clk) begin
        if (run_on) begin
            n_m = cyc - t0;
            if (n_m >= 1) begin
                comp = (n_m - 1) / L;
                if (comp > kmax + 1) comp = kmax + 1;
                ebusy = (n_m <= L * (kmax + 1)) ? 1 : 0;
                check("busy", busy, ebusy);
                check("sa_en", sa_en, ebusy);
                check("sacal_ena", sacal_ena, ebusy);
                check("done", done, 1 - ebusy);
                ec = (comp < kl[0]) ? comp : kl[0];
                check("code_0", code0, ec);
                ec = (comp < kl[1]) ? comp : kl[1];
                check("code_180", code180, ec);
                check("dir_0", dir0, (comp >= 1) ? pp[0] : 0);
                check("dir_180", dir180, (comp >= 1) ? pp[1] : 0);
                check("err_0", err0, (er[0] && comp >= 32) ? 1 : 0);
                check("err_180", err180, (er[1] && comp >= 32) ? 1 : 0);
                if (done && done_off < 0) done_off = n_m;
            end
        end
    end

    task automatic set_phase(input int ph, input int p, input int t, input int v, input logic [15:0] pat);
        pp[ph] = p; th[ph] = t; vs[ph] = v; vp[ph] = pat;
        if (v > 0 && ((($countones(pat) > NS / 2) ? 1 : 0) != p)) begin
            kl[ph] = v;  er[ph] = 1'b0;
        end else if (t <= 31) begin
            kl[ph] = t;  er[ph] = 1'b0;
        end else begin
            kl[ph] = 31; er[ph] = 1'b1;
        end
    endtask

    task automatic run_trial(input int sset, input bit poke);
        S    = (sset == 0) ? 1 : sset;
        L    = S + NS + 1;
        kmax = (kl[0] > kl[1]) ? kl[0] : kl[1];
        settle = 8'(sset);
        @(negedge clk);
        t0 = cyc;
        done_off = -1;
        start = 1'b1;
        run_on = 1'b1;
        for (int i = 0; i < L * (kmax + 1) + 4; i++) begin
            @(negedge clk);
            start = (poke && (cyc - t0) == L + S + 3) ? 1'b1 : 1'b0;
        end
        run_on = 1'b0;
        check("done_rise_model", done_off, L * (kmax + 1) + 1);
    endtask

    task automatic check_zero(input string name);
        check(name, int'({sa_en, sacal_ena, busy, done, code0, dir0, code180, dir180, err0, err180}), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; settle = 8'd4;
        set_phase(0, 0, 32, 0, 16'h0000);
        set_phase(1, 0, 32, 0, 16'h0000);
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        rst = 1'b0;
        @(negedge clk);
        check_zero("idle_state");

        // Phase 0 flips at code 6 (pol 0), phase 180 flips at code 3 (pol 1)
        set_phase(0, 0, 6, 0, 16'h0000);
        set_phase(1, 1, 3, 0, 16'h0000);
        run_trial(4, 1'b0);
        check("t1_code_0", code0, 6);
        check("t1_dir_0", dir0, 0);
        check("t1_err_0", err0, 0);
        check("t2_code_180", code180, 3);
        check("t2_dir_180", dir180, 1);
        check("t1_done_at", done_off, 148);

        // Both flip at code 2
        set_phase(0, 0, 2, 0, 16'h0000);
        set_phase(1, 1, 2, 0, 16'h0000);
        run_trial(4, 1'b0);
        check("t3_done_at", done_off, 64);
        check("t3_busy_after", busy, 0);

        // Phase 0 never flips; phase 180 locks early at 4
        set_phase(0, 0, 32, 0, 16'h0000);
        set_phase(1, 1, 4, 0, 16'h0000);
        run_trial(4, 1'b0);
        check("t4_code_0", code0, 31);
        check("t4_err_0", err0, 1);
        check("t4_code_180", code180, 4);
        check("t4_done_at", done_off, 673);

        // Majority vote at step 3: 9/16 ones flips pol 0; 8/16 (tie->0) flips pol 1
        set_phase(0, 0, 10, 3, 16'h01FF);
        set_phase(1, 1, 10, 3, 16'h00FF);
        run_trial(4, 1'b0);
        check("t5_vote9_code_0", code0, 3);
        check("t5_tie_code_180", code180, 3);
        // Tie keeps pol 0 and 9/16 keeps pol 1; start poked mid-SAMPLE must be ignored
        set_phase(0, 0, 7, 3, 16'h00FF);
        set_phase(1, 1, 5, 3, 16'h01FF);
        run_trial(4, 1'b1);
        check("t5_tie_code_0", code0, 7);
        check("t5_vote9_code_180", code180, 5);

        // Reset mid-SETTLE, then a clean run
        set_phase(0, 1, 5, 0, 16'h0000);
        set_phase(1, 0, 5, 0, 16'h0000);
        settle = 8'd4;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        check_zero("reset_mid_settle");
        rst = 1'b0;
        run_trial(4, 1'b0);
        check("t6_code_0", code0, 5);
        check("t6_dir_0", dir0, 1);

        // Settle of 0 behaves as 1 (L=18); constant data exhausts both phases
        set_phase(0, 1, 32, 0, 16'h0000);
        set_phase(1, 0, 32, 0, 16'h0000);
        run_trial(0, 1'b0);
        check("t6_s0_done_at", done_off, 577);
        check("t6_s0_err_180", err180, 1);

        // Randomized trials
        for (int r = 0; r < 6; r++) begin
            for (int ph = 0; ph < 2; ph++) begin
                int p, t, v;
                p = int'($urandom_range(0, 1));
                t = int'($urandom_range(1, 32));
                v = 0;
                if (t >= 2 && $urandom_range(0, 1) == 1) v = int'($urandom_range(1, t - 1));
                set_phase(ph, p, t, v, 16'($urandom));
            end
            run_trial(int'($urandom_range(2, 6)), r[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0d got=timeout exp=finish", cyc);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
